// File: rtl/timer_ctrl.sv
// timer_ctrl: start/stop/clear control FSM and one-second prescaler for a BCD countdown timer.
// Define ALARM_TIMEOUT_EN to return from ALARM to IDLE automatically after ALARM_SECS ticks.
module timer_ctrl #(
    parameter int TICK_DIV   = 100000000,
    parameter int ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       clear_btn,
    input  logic [3:0] seconds,
    input  logic [3:0] tens_seconds,
    input  logic [3:0] minutes,
    input  logic [3:0] tens_minutes,
    output logic       count_enable,
    output logic       main_enable,
    output logic       counter_reset,
    output logic       alarm,
    output logic [1:0] state
);
    localparam logic [1:0]  IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, ALARM = 2'b11;
    localparam logic [26:0] TICK_LAST = 27'(TICK_DIV - 1);
    logic [1:0]  next_state;
    logic [26:0] presc;
    logic        tick, zero, reload, alarm_done;
    // Non-BCD digit values are treated as nonzero, so only an exact 0000 reads as expired.
    assign zero = {tens_minutes, minutes, tens_seconds, seconds} == 16'd0;
    assign tick = presc == TICK_LAST;
`ifdef ALARM_TIMEOUT_EN
    localparam logic [7:0] ALARM_LAST = 8'(ALARM_SECS - 1);
    logic [7:0] alarm_cnt;
    always_ff @(posedge clk) begin
        if (reset || state != ALARM)
            alarm_cnt <= '0;
        else if (tick)
            alarm_cnt <= alarm_cnt + 8'd1;
    end
    assign alarm_done = tick && alarm_cnt == ALARM_LAST;
`else
    localparam int unused_alarm_secs = ALARM_SECS;
    assign alarm_done = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            counter_reset <= 1'b0;
        end else begin
            state         <= next_state;
            counter_reset <= reload;
        end
    end
    // A state change restarts the second, so every RUN entry waits a full TICK_DIV.
    always_ff @(posedge clk) begin
        if (reset || next_state != state || !(state == RUN || state == ALARM) || tick)
            presc <= '0;
        else
            presc <= presc + 27'd1;
    end
    always_comb begin
        next_state = state;
        reload     = 1'b0;
        case (state)
            IDLE: begin
                if (clear_btn)
                    reload = 1'b1;
                else if (!stop_btn && start_btn && !zero)
                    next_state = RUN;
            end
            RUN: begin
                if (clear_btn) begin
                    next_state = IDLE;
                    reload     = 1'b1;
                end else if (stop_btn)
                    next_state = PAUSE;
                else if (zero)
                    next_state = ALARM;
            end
            PAUSE: begin
                if (clear_btn) begin
                    next_state = IDLE;
                    reload     = 1'b1;
                end else if (!stop_btn && start_btn)
                    next_state = RUN;
            end
            default: begin
                if (clear_btn || stop_btn || start_btn || alarm_done) begin
                    next_state = IDLE;
                    reload     = 1'b1;
                end
            end
        endcase
    end
    always_comb begin
        main_enable  = state == RUN;
        alarm        = state == ALARM;
        count_enable = tick && state == RUN && !stop_btn;
    end
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed checks of timer_ctrl with TICK_DIV=4 and ALARM_SECS=3.
module tb_timer_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_btn = 1'b0, stop_btn = 1'b0, clear_btn = 1'b0;
    logic [3:0] seconds = '0, tens_seconds = '0, minutes = '0, tens_minutes = '0;
    logic       count_enable, main_enable, counter_reset, alarm;
    logic [1:0] state;
    int         checks = 0, errors = 0;
    logic [7:0] pat;
    logic       seen;

    timer_ctrl #(.TICK_DIV(4), .ALARM_SECS(3)) dut (
        .clk(clk), .reset(reset), .start_btn(start_btn), .stop_btn(stop_btn),
        .clear_btn(clear_btn), .seconds(seconds), .tens_seconds(tens_seconds),
        .minutes(minutes), .tens_minutes(tens_minutes), .count_enable(count_enable),
        .main_enable(main_enable), .counter_reset(counter_reset), .alarm(alarm),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        step;
        step;
        reset = 1'b0;
        check("rst_state", state, 0);
        check("rst_ce", count_enable, 0);
        check("rst_main", main_enable, 0);
        check("rst_cr", counter_reset, 0);
        check("rst_alarm", alarm, 0);

        // start with all-zero digits is ignored
        start_btn = 1'b1;
        step;
        start_btn = 1'b0;
        check("zero_start_state", state, 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen |= count_enable;
            step;
        end
        check("zero_start_ce", seen, 0);

        // run with 0,0,3,0: ticks at entry offsets 3 and 7
        minutes = 4'd3;
        start_btn = 1'b1;
        step;
        start_btn = 1'b0;
        check("run_state", state, 1);
        check("run_main", main_enable, 1);
        for (int i = 0; i < 8; i++) begin
            pat[i] = count_enable;
            step;
        end
        check("run_ce_pattern", pat, 8'h88);

        // stop coincident with a tick suppresses it
        step;
        step;
        step;
        stop_btn = 1'b1;
        #1;
        check("stop_tick_ce", count_enable, 0);
        step;
        stop_btn = 1'b0;
        check("pause_state", state, 2);
        check("pause_main", main_enable, 0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen |= count_enable;
            step;
        end
        check("pause_ce", seen, 0);

        // resume: next tick a full period later
        start_btn = 1'b1;
        step;
        start_btn = 1'b0;
        check("resume_state", state, 1);
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            pat[i] = count_enable;
            step;
        end
        check("resume_ce_pattern", pat, 8'h08);

        // reaching zero raises the alarm
        minutes = 4'd0;
        step;
        check("alarm_state", state, 3);
        check("alarm_out", alarm, 1);
        check("alarm_main", main_enable, 0);
`ifdef ALARM_TIMEOUT_EN
        seen = 1'b0;
        for (int i = 0; i < 11; i++) begin
            seen |= count_enable;
            step;
        end
        check("alarm_ce", seen, 0);
        check("alarm_hold11", state, 3);
        check("alarm_hold11_cr", counter_reset, 0);
        step;
        check("timeout_state", state, 0);
        check("timeout_cr", counter_reset, 1);
`else
        seen = 1'b0;
        pat[0] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            seen |= count_enable;
            pat[0] &= alarm;
            step;
        end
        check("alarm_ce", seen, 0);
        check("alarm_held", pat[0], 1);
        stop_btn = 1'b1;
        step;
        stop_btn = 1'b0;
        check("alarm_stop_state", state, 0);
        check("alarm_stop_cr", counter_reset, 1);
`endif
        step;
        check("alarm_cr_width", counter_reset, 0);

        // IDLE clear pulses counter_reset and stays IDLE
        minutes = 4'd3;
        clear_btn = 1'b1;
        step;
        clear_btn = 1'b0;
        check("idle_clear_state", state, 0);
        check("idle_clear_cr", counter_reset, 1);
        step;
        check("idle_clear_cr_width", counter_reset, 0);

        // stop outranks start in IDLE and in RUN
        stop_btn = 1'b1;
        start_btn = 1'b1;
        step;
        stop_btn = 1'b0;
        check("idle_prio_state", state, 0);
        step;
        check("run2_state", state, 1);
        stop_btn = 1'b1;
        step;
        stop_btn = 1'b0;
        start_btn = 1'b0;
        check("run_prio_state", state, 2);

        // clear outranks start in PAUSE
        clear_btn = 1'b1;
        start_btn = 1'b1;
        step;
        clear_btn = 1'b0;
        start_btn = 1'b0;
        check("pause_clear_state", state, 0);
        check("pause_clear_cr", counter_reset, 1);
        step;
        check("pause_clear_cr_width", counter_reset, 0);

        // non-BCD digit counts as nonzero; reset in RUN overrides a clear
        minutes = 4'd0;
        seconds = 4'hA;
        start_btn = 1'b1;
        step;
        start_btn = 1'b0;
        check("nonbcd_state", state, 1);
        step;
        step;
        step;
        reset = 1'b1;
        clear_btn = 1'b1;
        step;
        check("rstrun_state", state, 0);
        check("rstrun_main", main_enable, 0);
        check("rstrun_ce", count_enable, 0);
        check("rstrun_cr", counter_reset, 0);
        check("rstrun_alarm", alarm, 0);
        reset = 1'b0;
        clear_btn = 1'b0;
        step;
        check("rstrun_cr_after", counter_reset, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000000, clk cycles per one-second tick; legal range 2..2^27-1.
REQ-002 Parameter ALARM_SECS, default 10, alarm duration in ticks when ALARM_TIMEOUT_EN is defined; legal range 1..255.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start_btn  input  1  single-cycle, externally debounced start/resume request.
REQ-006 stop_btn  input  1  single-cycle, externally debounced pause request.
REQ-007 clear_btn  input  1  single-cycle, externally debounced abort/reload request.
REQ-008 seconds, tens_seconds, minutes, tens_minutes  input  4 each  current BCD digits from the countdown counter.
REQ-009 count_enable  output  1  one-cycle decrement tick to the countdown counter.
REQ-010 main_enable  output  1  counter run gate; high only in RUN.
REQ-011 counter_reset  output  1  one-cycle pulse that reloads the counter from its programmed value.
REQ-012 alarm  output  1  high only in ALARM.
REQ-013 state  output  2  current state encoding.

Function
REQ-014 States SHALL be IDLE=00, RUN=01, PAUSE=10, ALARM=11, held in registers.
REQ-015 zero SHALL be true when all four digit inputs equal 0; any nonzero or non-BCD value (>9) counts as nonzero.
REQ-016 Button priority per cycle SHALL be clear_btn > stop_btn > start_btn; only the highest-priority asserted button acts.
REQ-017 IDLE: start_btn with !zero -> RUN; start_btn with zero -> stay IDLE; clear_btn -> stay IDLE and pulse counter_reset.
REQ-018 RUN: clear_btn -> IDLE with counter_reset pulse; else stop_btn -> PAUSE; else zero -> ALARM.
REQ-019 PAUSE: clear_btn -> IDLE with counter_reset pulse; else start_btn -> RUN; zero is not evaluated in PAUSE.
REQ-020 ALARM: any button -> IDLE with counter_reset pulse.
REQ-021 counter_reset SHALL be registered and high exactly one cycle, the cycle after the triggering edge, coincident with state==IDLE.
REQ-022 The prescaler SHALL count 0..TICK_DIV-1 while in RUN or ALARM, wrap to 0, and be forced to 0 in IDLE, PAUSE and on every state change.
REQ-023 The internal tick SHALL fire for one cycle when the prescaler equals TICK_DIV-1; the first tick after entering RUN occurs TICK_DIV cycles after entry.
REQ-024 count_enable SHALL equal the tick qualified by state==RUN and must never be high in any other state.
REQ-025 main_enable SHALL be high iff state==RUN; alarm SHALL be high iff state==ALARM; both registered-state decodes with no extra latency.
REQ-026 A stop_btn arriving in the same cycle as a tick SHALL suppress that tick.

Reset
REQ-027 On reset high at a clk edge: state=IDLE, prescaler=0, alarm-second counter=0, count_enable=0, main_enable=0, counter_reset=0, alarm=0.
REQ-028 Reset SHALL override all buttons; reset asserted in mid-RUN or mid-ALARM returns to IDLE on the next edge, with no counter_reset pulse generated.

Configuration
REQ-029 Macro ALARM_TIMEOUT_EN: when defined, an 8-bit counter SHALL count ticks in ALARM; on the ALARM_SECS-th tick, state SHALL go to IDLE with a counter_reset pulse; the counter clears on entering ALARM.
REQ-030 When ALARM_TIMEOUT_EN is undefined, ALARM SHALL persist until a button or reset, and the alarm counter SHALL not be synthesized.

Verification (TICK_DIV=4, ALARM_SECS=3)
REQ-031 Digits 0,0,0,0 in IDLE, start_btn pulse -> state stays 00, count_enable never high.
REQ-032 Digits 0,0,3,0, start_btn -> state=01 next cycle, count_enable pulses every 4 cycles, first at entry+4; digits driven 0,0,0,0 -> state=11, alarm=1 next cycle.
REQ-033 In RUN, stop_btn coincident with tick -> no count_enable that cycle, state=10; start_btn -> RUN, next tick 4 cycles later.
REQ-034 In PAUSE, clear_btn and start_btn same cycle -> state=00, counter_reset high exactly 1 cycle.
REQ-035 ALARM with ALARM_TIMEOUT_EN defined -> after 12 cycles state=00, counter_reset pulse; undefined -> alarm held 100 cycles until stop_btn, then IDLE plus pulse.
REQ-036 reset asserted in RUN -> all outputs 0 and state=00 next edge, counter_reset stays 0.
